// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution frame sequencer.
package conv_pkg;
  localparam int PIX_W     = 8;
  localparam int KERN_TAPS = 9;
  localparam int ACC_W     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/conv_frame_ctrl_if.sv
// Pixel source, pixel sink, result source and result sink signals of the frame sequencer.
interface conv_frame_ctrl_if;
  import conv_pkg::*;

  logic                    src_valid;
  logic [PIX_W-1:0]        src_data;
  logic                    src_ready;
  logic                    pixel_valid;
  logic [PIX_W-1:0]        pixel_out;
  logic                    conv_valid;
  logic signed [ACC_W-1:0] conv_in;
  logic                    res_valid;
  logic signed [ACC_W-1:0] res_data;
  logic                    res_last;

  modport master (
    output src_valid, src_data, conv_valid, conv_in,
    input  src_ready, pixel_valid, pixel_out, res_valid, res_data, res_last
  );

  modport slave (
    input  src_valid, src_data, conv_valid, conv_in,
    output src_ready, pixel_valid, pixel_out, res_valid, res_data, res_last
  );
endinterface

// File: rtl/conv_kernel_reg.sv
// Serial-in 9x8 coefficient register; a write after a complete load restarts at tap 0.
module conv_kernel_reg
  import conv_pkg::*;
(
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         wr_en,
  input  logic [PIX_W-1:0]             wr_data,
  output logic [KERN_TAPS*PIX_W-1:0]   kernel,
  output logic                         ready
);
  localparam logic [3:0] KIDX_LAST = 4'(KERN_TAPS - 1);

  logic [3:0] kidx;

  always_ff @(posedge clk) begin
    if (clr) begin
      kernel <= '0;
      kidx   <= '0;
      ready  <= 1'b0;
    end else if (wr_en) begin
      if (ready) begin
        kernel[PIX_W-1:0] <= wr_data;
        kidx              <= 4'd1;
        ready             <= 1'b0;
      end else begin
        for (int k = 0; k < KERN_TAPS; k++) begin
          if (kidx == 4'(k)) kernel[k*PIX_W +: PIX_W] <= wr_data;
        end
        if (kidx == KIDX_LAST) begin
          kidx  <= '0;
          ready <= 1'b1;
        end else begin
          kidx <= kidx + 4'd1;
        end
      end
    end
  end
endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer above conv_top: loads the kernel, streams one frame in, collects results.
//   state | meaning
//   IDLE  | kernel loading allowed, waiting for start with a full kernel
//   RUN   | accepting source pixels until NPIX have been forwarded
//   DRAIN | source closed, waiting for the last result or the drain timeout
//   DONE  | one-cycle end-of-frame pulse
module conv_frame_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8,
  parameter int DRAIN_MAX = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       kern_wr_en,
  input  logic [PIX_W-1:0]           kern_wr_data,
  output logic                       kern_ready,
  output logic [KERN_TAPS*PIX_W-1:0] kernel_out,
  conv_frame_ctrl_if.slave           stream,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int NOUT = (IMG_W - 2) * (IMG_H - 2);
  localparam int PCW  = $clog2(NPIX + 1);
  localparam int OCW  = $clog2(NOUT + 1);
  localparam int DCW  = $clog2(DRAIN_MAX + 1);

  localparam logic [PCW-1:0] PIX_LAST   = PCW'(NPIX - 1);
  localparam logic [OCW-1:0] NOUT_C     = OCW'(NOUT);
  localparam logic [OCW-1:0] NOUT_LAST  = OCW'(NOUT - 1);
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_MAX - 1);

  state_t         state;
  logic [PCW-1:0] pix_cnt;
  logic [OCW-1:0] out_cnt;
  logic [DCW-1:0] drain_cnt;

  conv_kernel_reg u_kernel (
    .clk     (clk),
    .clr     (rst),
    .wr_en   (kern_wr_en && (state == IDLE)),
    .wr_data (kern_wr_data),
    .kernel  (kernel_out),
    .ready   (kern_ready)
  );

  assign stream.src_ready = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      pix_cnt            <= '0;
      out_cnt            <= '0;
      drain_cnt          <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      err                <= 1'b0;
      stream.pixel_valid <= 1'b0;
      stream.pixel_out   <= '0;
      stream.res_valid   <= 1'b0;
      stream.res_data    <= '0;
      stream.res_last    <= 1'b0;
    end else begin
      stream.pixel_valid <= 1'b0;
      stream.res_valid   <= 1'b0;
      stream.res_last    <= 1'b0;

      case (state)
        IDLE: begin
          if (start && kern_ready) begin
            state   <= RUN;
            pix_cnt <= '0;
            out_cnt <= '0;
            err     <= 1'b0;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          if (stream.src_valid) begin
            stream.pixel_valid <= 1'b1;
            stream.pixel_out   <= stream.src_data;
            pix_cnt            <= pix_cnt + PCW'(1);
            if (pix_cnt == PIX_LAST) begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end
        end
        DRAIN: begin
          // A complete result set wins over a timeout landing in the same cycle.
          if (out_cnt == NOUT_C) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (drain_cnt == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DCW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Results outside RUN/DRAIN or beyond NOUT are dropped and flagged.
      if (stream.conv_valid) begin
        if ((state == RUN || state == DRAIN) && out_cnt != NOUT_C) begin
          stream.res_valid <= 1'b1;
          stream.res_data  <= stream.conv_in;
          stream.res_last  <= (out_cnt == NOUT_LAST);
          out_cnt          <= out_cnt + OCW'(1);
        end else begin
          err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/conv_frame_ctrl.md
# conv_frame_ctrl

Frame-level sequencer for the 3x3 convolution engine. Serially loads the nine kernel coefficients into a 72-bit kernel register and streams one IMG_W x IMG_H frame from a ready/valid pixel source into `conv_top`. Collects the engine's results and tags the last one. Sits directly above `conv_top`: it drives `pixel_valid`, `pixel_in` and `kernel_in`, and consumes `conv_out` and `conv_valid`.

## Interface
- IMG_W, 8: frame width in pixels; minimum 3.
- IMG_H, 8: frame height in pixels; minimum 3.
- DRAIN_MAX, 64: cycles allowed in DRAIN before timeout.

Clock and reset: one clock; reset is synchronous and active-high. Both sit on the `clk` and `rst` ports below.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle frame start request.
- kern_wr_en  in  1  coefficient write strobe.
- kern_wr_data  in  8  coefficient byte.
- kern_ready  out  1  all 9 coefficients loaded.
- kernel_out  out  72  to `conv_top.kernel_in`; tap k in bits [8k+7:8k].
- src_valid  in  1  source pixel valid.
- src_data  in  8  source pixel.
- src_ready  out  1  controller accepts a pixel.
- pixel_valid  out  1  to `conv_top.pixel_valid`.
- pixel_out  out  8  to `conv_top.pixel_in`.
- conv_valid  in  1  from `conv_top`.
- conv_in  in  signed 16  from `conv_top.conv_out`.
- res_valid  out  1  result valid.
- res_data  out  signed 16  result.
- res_last  out  1  marks the final result of the frame.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle end-of-frame pulse.
- err  out  1  sticky error flag; cleared by an accepted start.

## Operation
Fixed values:
- NPIX = IMG_W*IMG_H.
- NOUT = (IMG_W-2)*(IMG_H-2).

States:
- **IDLE**
  - Each kern_wr_en writes kern_wr_data into tap kidx, then kidx increments; 8 wraps to 0.
  - kern_ready rises after the 9th write.
  - A write while kern_ready=1 restarts the load: tap 0 is overwritten, kidx goes to 1, kern_ready drops.
  - start with kern_ready=1 goes to RUN and clears pix_cnt, out_cnt and err.
  - start with kern_ready=0 is ignored.
- **RUN**
  - src_ready = 1.
  - Each src_valid&&src_ready handshake forwards the pixel and increments pix_cnt.
  - The handshake that brings pix_cnt to NPIX goes to DRAIN; src_ready is 0 from the next cycle.
- **DRAIN**
  - src_ready = 0.
  - The cycle counter runs from entry.
  - out_cnt reaching NOUT goes to DONE.
  - Counter reaching DRAIN_MAX sets err and goes to DONE.
- **DONE**
  - done = 1 for this one cycle, then IDLE.

Result handling:
- In RUN and DRAIN, each conv_valid is forwarded as a result and increments out_cnt, while out_cnt < NOUT.
- res_last = 1 on the result that brings out_cnt to NOUT.
- conv_valid with out_cnt = NOUT, or in IDLE or DONE, is dropped and sets err.

Other rules:
- kern_wr_en outside IDLE is ignored; kernel_out holds stable from start to done.
- start outside IDLE is ignored.
- Reset mid-frame returns to IDLE, clears the kernel and all counters, and drops any in-flight pixel or result.

Widths and arithmetic:
- pix_cnt width is $clog2(NPIX+1); out_cnt width is $clog2(NOUT+1).
- Results pass through unmodified: no saturation, no sign change.

## Timing
- Reset values:
  - all outputs 0: kernel_out=72'h0, pixel_out=0, res_data=0;
  - state IDLE, kidx=0.
- src_ready is a combinational decode of state. With start at cycle t, src_ready=1 from t+1.
- Pixel path: 1-cycle register. A handshake at cycle n gives pixel_valid=1 and pixel_out=src_data at n+1. src_valid with src_ready=0 gives no pixel_valid.
- Result path: 1-cycle register. conv_valid at cycle n gives res_valid, res_data and res_last at n+1.
- done asserts in the cycle after the final res_valid, or in the cycle after timeout.
- busy falls in the same cycle done rises.
- kern_ready rises the cycle after the 9th write. A start in that same write cycle is ignored.

## Structure
Shared package `conv_pkg`:
- constants PIX_W=8, KERN_TAPS=9, ACC_W=16;
- state enum {IDLE, RUN, DRAIN, DONE}.

Sub-module `conv_kernel_reg`:
- serial-in 9x8 tap register with index counter and kern_ready;
- synchronous clear;
- write enable is gated by the parent's IDLE state.

## Test plan
- **Kernel load:** write 9 bytes 0x01..0x09, then read kernel_out → 72'h090807060504030201, kern_ready=1. A 10th write of 0xFF → tap0 = 0xFF, kern_ready=0.
- **Full frame, 8x8:** 64 pixels presented back-to-back, model drives 36 conv_valid pulses → 64 pixel_valid, 36 res_valid, res_last only on the 36th, one done, err=0.
- **Source stalls:** src_valid toggled 1/0 over 64 pixels → pixel_valid count 64, no pixel forwarded while src_ready=0.
- **Start without kernel:** only 5 taps loaded, start pulsed → state stays IDLE, src_ready=0, busy=0.
- **Drain timeout:** model returns only 30 of 36 results → err=1 and done exactly 64 cycles after DRAIN entry. A following start clears err.
- **Reset mid-frame:** rst after pixel 20 → next cycle all outputs 0, kern_ready=0. A new kernel load plus full frame completes normally.
